// File: rtl/friscv_decode_pkg.sv
// Shared decode constants for the friscv decode stage: RV32I/RV64I base opcodes,
// one-hot instruction-class bit positions and the immediate-format selector.
package friscv_decode_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int ICLASS_W     = 16;
  localparam int IC_LUI       = 0;
  localparam int IC_AUIPC     = 1;
  localparam int IC_JAL       = 2;
  localparam int IC_JALR      = 3;
  localparam int IC_BRANCH    = 4;
  localparam int IC_LOAD      = 5;
  localparam int IC_STORE     = 6;
  localparam int IC_ALU_IMM   = 7;
  localparam int IC_ALU_REG   = 8;
  localparam int IC_ALU_IMM_W = 9;
  localparam int IC_ALU_REG_W = 10;
  localparam int IC_FENCE     = 11;
  localparam int IC_FENCE_I   = 12;
  localparam int IC_ECALL     = 13;
  localparam int IC_EBREAK    = 14;
  localparam int IC_CSR       = 15;

  // Raw fields + shamt + iclass + error; the bundle adds imm and pc on top.
  localparam int FIELDS_W = 72;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/friscv_decode_comb.sv
// Purely combinational RV32I/RV64I decoder: raw fields, one-hot class, sign-extended
// immediate and illegal-encoding flag; zero latency, no flow control of its own.
module friscv_decode_comb
  import friscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]         i_instr,
  output logic [6:0]          o_opcode,
  output logic [2:0]          o_funct3,
  output logic [6:0]          o_funct7,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [4:0]          o_rd,
  output logic [11:0]         o_csr,
  output logic [4:0]          o_zimm,
  output logic [5:0]          o_shamt,
  output logic [XLEN-1:0]     o_imm,
  output logic [ICLASS_W-1:0] o_iclass,
  output logic                o_error
);

  imm_fmt_e              w_fmt;
  logic [ICLASS_W-1:0]   w_class;
  logic                  w_err;
  logic [XLEN-1:0]       w_imm_i;
  logic [XLEN-1:0]       w_imm_s;
  logic [XLEN-1:0]       w_imm_b;
  logic [XLEN-1:0]       w_imm_u;
  logic [XLEN-1:0]       w_imm_j;

  assign o_opcode = i_instr[6:0];
  assign o_funct3 = i_instr[14:12];
  assign o_funct7 = i_instr[31:25];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_rd     = i_instr[11:7];
  assign o_csr    = i_instr[31:20];
  assign o_zimm   = i_instr[19:15];
  assign o_shamt  = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  assign w_imm_i = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

  always_comb begin
    w_fmt   = IMM_NONE;
    w_class = '0;
    w_err   = 1'b0;
    case (i_instr[6:0])
      OPC_LUI:    begin w_class[IC_LUI]    = 1'b1; w_fmt = IMM_U; end
      OPC_AUIPC:  begin w_class[IC_AUIPC]  = 1'b1; w_fmt = IMM_U; end
      OPC_JAL:    begin w_class[IC_JAL]    = 1'b1; w_fmt = IMM_J; end
      OPC_JALR:   begin w_class[IC_JALR]   = 1'b1; w_fmt = IMM_I; end
      OPC_BRANCH: begin w_class[IC_BRANCH] = 1'b1; w_fmt = IMM_B; end
      OPC_LOAD:   begin w_class[IC_LOAD]   = 1'b1; w_fmt = IMM_I; end
      OPC_STORE:  begin w_class[IC_STORE]  = 1'b1; w_fmt = IMM_S; end
      OPC_OP_IMM: begin
        w_class[IC_ALU_IMM] = 1'b1;
        w_fmt               = IMM_I;
        // SLLI/SRLI/SRAI: shamt[5] only exists on RV64
        if (XLEN == 32 && i_instr[13:12] == 2'b01 && i_instr[25]) w_err = 1'b1;
      end
      OPC_OP:     w_class[IC_ALU_REG] = 1'b1;
      OPC_OP_IMM_32: begin
        w_fmt = IMM_I;
        if (XLEN == 64) w_class[IC_ALU_IMM_W] = 1'b1;
        else            w_err                 = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN == 64) w_class[IC_ALU_REG_W] = 1'b1;
        else            w_err                 = 1'b1;
      end
      OPC_MISC_MEM: begin
        if (i_instr[12]) w_class[IC_FENCE_I] = 1'b1;
        else             w_class[IC_FENCE]   = 1'b1;
      end
      OPC_SYSTEM: begin
        if (i_instr[14:12] != 3'b000) w_class[IC_CSR]    = 1'b1;
        else if (i_instr[20])         w_class[IC_EBREAK] = 1'b1;
        else                          w_class[IC_ECALL]  = 1'b1;
      end
      default:    w_err = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) w_err = 1'b1;
    if (w_err) w_class = '0;
  end

  always_comb begin
    case (w_fmt)
      IMM_I:   o_imm = w_imm_i;
      IMM_S:   o_imm = w_imm_s;
      IMM_B:   o_imm = w_imm_b;
      IMM_U:   o_imm = w_imm_u;
      IMM_J:   o_imm = w_imm_j;
      default: o_imm = '0;
    endcase
  end

  assign o_iclass = w_class;
  assign o_error  = w_err;

endmodule

// File: rtl/friscv_decode_stage.sv
// Registered decode stage: 1-cycle latency, full throughput; a main + skid register pair
// absorbs one beat of backpressure so inst_ready is a flop (low only while skid is full).
module friscv_decode_stage
  import friscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                aclk,
  input  logic                srst,
  input  logic                flush,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [31:0]         instruction,
  input  logic [XLEN-1:0]     inst_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [XLEN-1:0]     dec_pc,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [11:0]         csr,
  output logic [4:0]          zimm,
  output logic [5:0]          shamt,
  output logic [XLEN-1:0]     imm,
  output logic [ICLASS_W-1:0] iclass,
  output logic                inst_error
);

  localparam int DW = 2 * XLEN + FIELDS_W;

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic [4:0]          w_rd;
  logic [11:0]         w_csr;
  logic [4:0]          w_zimm;
  logic [5:0]          w_shamt;
  logic [XLEN-1:0]     w_imm;
  logic [ICLASS_W-1:0] w_iclass;
  logic                w_error;
  logic [DW-1:0]       w_dec;
  logic                w_in_fire;
  logic                w_main_free;

  logic [DW-1:0]       r_main;
  logic                r_main_vld;
  logic [DW-1:0]       r_skid;
  logic                r_skid_vld;
  logic                r_inst_ready;

  friscv_decode_comb #(.XLEN(XLEN)) u_comb (
    .i_instr  (instruction),
    .o_opcode (w_opcode),
    .o_funct3 (w_funct3),
    .o_funct7 (w_funct7),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd),
    .o_csr    (w_csr),
    .o_zimm   (w_zimm),
    .o_shamt  (w_shamt),
    .o_imm    (w_imm),
    .o_iclass (w_iclass),
    .o_error  (w_error)
  );

  assign w_dec = {inst_pc, w_imm, w_opcode, w_funct3, w_funct7, w_rs1, w_rs2, w_rd,
                  w_csr, w_zimm, w_shamt, w_iclass, w_error};

  assign w_in_fire   = inst_valid & r_inst_ready;
  assign w_main_free = ~r_main_vld | dec_ready;

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_main       <= '0;
      r_main_vld   <= 1'b0;
      r_skid       <= '0;
      r_skid_vld   <= 1'b0;
      r_inst_ready <= 1'b0;
    end else if (flush) begin
      r_main_vld   <= 1'b0;
      r_skid_vld   <= 1'b0;
      r_inst_ready <= 1'b1;
    end else if (w_main_free) begin
      // Skid is always older than anything arriving, and inst_ready is low while it is full
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
      end else if (w_in_fire) begin
        r_main     <= w_dec;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
      r_skid_vld   <= 1'b0;
      r_inst_ready <= 1'b1;
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_vld   <= 1'b1;
      r_inst_ready <= 1'b0;
    end
  end

  assign inst_ready = r_inst_ready;
  assign dec_valid  = r_main_vld;
  assign {dec_pc, imm, opcode, funct3, funct7, rs1, rs2, rd,
          csr, zimm, shamt, iclass, inst_error} = r_main;

endmodule

// File: doc/friscv_decode_stage.md
# friscv_decode_stage

Registered, parametrised instruction-decode stage for the friscv core, placed between instruction fetch and the control/processing units. It accepts a raw instruction plus PC on a valid/ready stream, decodes it (RV32I or RV64I base, selected by XLEN) into fields, a one-hot instruction class and a fully sign-extended XLEN immediate, and presents the result one cycle later on a second valid/ready stream. A two-entry skid buffer keeps `inst_ready` registered, and a flush input discards in-flight instructions on a control-flow change.

## Interface
- `XLEN`, 32: datapath width; only 32 or 64 are legal. 64 enables the OP-IMM-32 and OP-32 opcodes and 6-bit shamt.
- `aclk` in 1: clock.
- `srst` in 1: synchronous reset, active-high.
- `flush` in 1: drops every held and incoming instruction.
- `inst_valid` in 1, `inst_ready` out 1: input handshake.
- `instruction` in 32: raw instruction.
- `inst_pc` in XLEN: instruction address.
- `dec_valid` out 1, `dec_ready` in 1: output handshake.
- `dec_pc` out XLEN: PC of the decoded instruction.
- `opcode` out 7, `funct3` out 3, `funct7` out 7, `rs1`/`rs2`/`rd` out 5 each, `csr` out 12, `zimm` out 5: raw fields.
- `shamt` out 6: instruction[25:20]; bit 5 is forced to 0 when XLEN=32.
- `imm` out XLEN: immediate for the format, sign-extended.
- `iclass` out 16: one-hot class vector.
- `inst_error` out 1: illegal or unsupported encoding; `iclass` is 0 when set.

## Operation
- **Immediate formats:**
  - I: instruction[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All formats sign-extend from instruction[31] to XLEN.
  - imm=0 for R-type, FENCE and SYSTEM.
- **iclass bit order (0..15):** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU_REG, ALU_IMM_W, ALU_REG_W, FENCE, FENCE_I, ECALL, EBREAK, CSR.
- **SYSTEM opcode:**
  - funct3=0 and instruction[20]=0 gives ECALL.
  - funct3=0 and instruction[20]=1 gives EBREAK.
  - funct3≠0 gives CSR.
- **MISC-MEM opcode:** funct3[0]=1 gives FENCE_I; otherwise FENCE.
- **inst_error=1 for any of:**
  - an unknown opcode;
  - instruction[1:0]≠2'b11;
  - OP-IMM-32 or OP-32 with XLEN=32;
  - SLLI/SRLI/SRAI with instruction[25]=1 and XLEN=32.
- Raw fields always pass through, including when inst_error=1.
- **Storage:** a main output register plus one skid register, 2 entries total.
  - `inst_ready` = skid register empty, and is itself a flop.
  - Input transfer: `inst_valid & inst_ready`.
  - Output transfer: `dec_valid & dec_ready`.
  - Entries leave in strict arrival order.
- **Flush:** in the flush cycle both entries are invalidated and any input transfer in that cycle is discarded. The next cycle has dec_valid=0 and inst_ready=1.
- **Reset values:** dec_valid=0, inst_ready=0 during srst and 1 from the first cycle after release; all data outputs 0.

## Timing
- Latency: an input accepted at edge N gives dec_valid=1 with its bundle after edge N (1 cycle) when the output is empty or being consumed.
- Throughput: 1 instruction per cycle while dec_ready=1.
- Stall (dec_valid=1, dec_ready=0, new input accepted): the decoded word goes to the skid register and inst_ready falls after that edge.
- Skid drain: when the main register is consumed, skid moves to main in the same edge and inst_ready rises after that edge.
- Output data stays stable while dec_valid=1 and dec_ready=0.
- Simultaneous input and output transfer with skid empty: main reloads and no bubble appears.
- `flush` and `srst` together: srst dominates.
- srst asserted mid-stall: all entries are lost and no output transfer occurs in that cycle.

## Structure
- Package `friscv_decode_pkg`: opcode localparams, iclass index constants and width, immediate-format enum (I/S/B/U/J/NONE).
- Sub-module `friscv_decode_comb`: combinational field, class, immediate and error logic, parametrised by XLEN. It is instantiated once on the input path, so stored entries hold already-decoded bundles.
- Top level: the two registers, occupancy control and flush.

## Test plan
- **Basic decode:** XLEN=32, `0x00500093` (addi x1,x0,5) then `0xFFF00093`.
  - First: iclass[7]=1, rd=1, imm=5.
  - Second: imm=0xFFFFFFFF.
  - Each appears 1 cycle after acceptance.
- **JAL:** `0x008000EF` → iclass[2]=1, rd=1, imm=8. With XLEN=64 the same input gives imm=64'h8.
- **Shift/W-op legality:**
  - `0x02009093` (slli x1,x1,32): inst_error=1 at XLEN=32; iclass[7]=1 and shamt=32 at XLEN=64.
  - `0x0010809B` (addiw): inst_error=1 at XLEN=32; iclass[9]=1 and imm=1 at XLEN=64.
- **Backpressure:** dec_ready=0 while 3 back-to-back instructions are offered.
  - Exactly 2 are accepted and inst_ready falls.
  - Releasing dec_ready yields all 3 in order with no duplicates.
- **Flush during stall:** both entries full, flush=1 for 1 cycle.
  - Next cycle: dec_valid=0 and inst_ready=1.
  - The instruction offered in the flush cycle never appears.
- **Reset mid-operation:** srst during a stream.
  - Outputs are 0 and dec_valid=0 the following cycle.
  - After release, the first new instruction decodes correctly.
